decoy_sched: RTL and testbench

//  Sequencer for the decoy-state datapath in the clk240 domain. Arms on PPS, holds the decoy

---
 rtl/decoy_sched_pkg.sv | 27 ++
 rtl/decoy_sched_pps_sync_edge.sv | 22 ++
 rtl/decoy_sched.sv | 177 +++++++++++++++++
 tb/tb_decoy_sched.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoy_sched_pkg.sv
// Shared types and constants for the decoy-state sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package decoy_sched_pkg;

   // Sequencer state encoding; the numeric values are visible on debug taps.
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_PPS = 3'd1,
      ST_RST      = 3'd2,
      ST_RUN      = 3'd3,
      ST_HOLD     = 3'd4,
      ST_ERR      = 3'd5
   } state_t;

   // Smallest strobe period; shorter settings are clamped up to this.
   localparam int DIV_MIN = 2;

   // 1.1 s of clk240 cycles without a PPS edge counts as PPS loss.
   localparam int PPS_TIMEOUT_DEF = 264_000_000;

   // 16-bit counter increment that sticks at all-ones.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/decoy_sched_pps_sync_edge.sv
// PPS synchroniser: 2-FF metastability guard plus rising-edge pulse generator.
// Latency: pps_edge is high for one cycle, acted on 3 clock edges after pps_async rises.
// Backpressure: none; every rising edge yields exactly one pulse.
// Ports: clk/rst_n (async active-low), pps_async (raw PPS), pps_edge (1-cycle pulse).
module decoy_sched_pps_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic pps_async,
   output logic pps_edge
);

   // sh[0], sh[1] form the synchroniser; sh[2] is the previous synchronised level.
   logic [2:0] sh;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sh <= '0;
      else        sh <= {sh[1:0], pps_async};
   end

   assign pps_edge = sh[1] & ~sh[2];

endmodule

// File: rtl/decoy_sched.sv
// Decoy-state sequencer: arms on PPS, holds datapath reset, then paces RNG pops into decoy/signal picks.
// Latency: strobe (rng_rd/rd_en_o/decoy_sel) registered one cycle after the divider tick.
// Backpressure: empty RNG FIFO at a tick skips the strobe and flags underflow; nothing stalls.
// Ports: clk240, rst_240_n (async active-low), en, cfg_* (live), pps_i (async), rng_empty/rng_value
//        (FWFT head) in; rng_rd, rd_en_o, decoy_sel, decoy_rst, busy, pps_lost, underflow, stat_* out.
// Build option: DECOY_SCHED_STATS_EN adds per-PPS-window decoy/signal/miss counters on stat_*.
module decoy_sched
   import decoy_sched_pkg::*;
#(
   parameter int DIV_W       = 8,
   parameter int BURST_W     = 16,
   parameter int RST_CYCLES  = 4,
   parameter int PPS_TIMEOUT = PPS_TIMEOUT_DEF,
   parameter int TMO_W       = 28
) (
   input  logic               clk240,
   input  logic               rst_240_n,
   input  logic               en,
   input  logic [DIV_W-1:0]   cfg_rd_div,
   input  logic [3:0]         cfg_thresh,
   input  logic [BURST_W-1:0] cfg_burst_len,
   input  logic               cfg_resync,
   input  logic               pps_i,
   input  logic               rng_empty,
   input  logic [3:0]         rng_value,
   output logic               rng_rd,
   output logic               rd_en_o,
   output logic               decoy_sel,
   output logic               decoy_rst,
   output logic               busy,
   output logic               pps_lost,
   output logic               underflow,
   output logic [15:0]        stat_decoy,
   output logic [15:0]        stat_signal,
   output logic [15:0]        stat_miss
);

   localparam int RC_W = $clog2(RST_CYCLES + 1);

   state_t             state, state_nxt;
   logic               pps_edge, active, wrap, tick, pop, miss, last_pop, wd_exp, is_decoy;
   logic [DIV_W-1:0]   div_cfg, div_cur, div_cnt;
   logic [BURST_W-1:0] burst_cnt;
   logic [RC_W-1:0]    rst_cnt;
   logic [TMO_W-1:0]   wd_cnt;

   decoy_sched_pps_sync_edge u_pps (
      .clk       (clk240),
      .rst_n     (rst_240_n),
      .pps_async (pps_i),
      .pps_edge  (pps_edge)
   );

   assign div_cfg  = (cfg_rd_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : cfg_rd_div;
   assign active   = (state == ST_RST) || (state == ST_RUN) || (state == ST_HOLD);
   assign wrap     = (div_cnt == div_cur - DIV_W'(1));
   // A PPS edge re-phases the divider, so it suppresses a coincident tick.
   assign tick     = (state == ST_RUN) && en && !pps_edge && wrap;
   assign pop      = tick && !rng_empty;
   assign miss     = tick && rng_empty;
   assign last_pop = pop && (cfg_burst_len != '0) &&
                     (burst_cnt + BURST_W'(1) == cfg_burst_len);
   assign wd_exp   = active && !pps_edge && (wd_cnt == TMO_W'(PPS_TIMEOUT - 1));
   assign is_decoy = (rng_value < cfg_thresh);

   // ---------------- state register ----------------
   always_ff @(posedge clk240 or negedge rst_240_n) begin
      if (!rst_240_n) state <= ST_IDLE;
      else            state <= state_nxt;
   end

   // ---------------- next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:     state_nxt = ST_WAIT_PPS;
         ST_WAIT_PPS: if (pps_edge) state_nxt = ST_RST;
         ST_RST:      if (rst_cnt == RC_W'(RST_CYCLES - 1)) state_nxt = ST_RUN;
         ST_RUN: begin
            if (pps_edge)      state_nxt = cfg_resync ? ST_RST : ST_RUN;
            else if (last_pop) state_nxt = ST_HOLD;
         end
         ST_HOLD:     if (pps_edge) state_nxt = cfg_resync ? ST_RST : ST_RUN;
         ST_ERR:      state_nxt = ST_ERR;
         default:     state_nxt = ST_IDLE;
      endcase
      if (wd_exp) state_nxt = ST_ERR;
      if (!en)    state_nxt = ST_IDLE;
   end

   // ---------------- state-decoded outputs ----------------
   always_comb begin
      decoy_rst = !((state == ST_RUN) || (state == ST_HOLD));
      busy      = active;
   end

   // ---------------- pacing counters ----------------
   always_ff @(posedge clk240 or negedge rst_240_n) begin
      if (!rst_240_n) begin
         rst_cnt   <= '0;
         div_cnt   <= '0;
         div_cur   <= DIV_W'(DIV_MIN);
         burst_cnt <= '0;
         wd_cnt    <= '0;
      end else begin
         rst_cnt <= (state == ST_RST) ? rst_cnt + RC_W'(1) : '0;

         // The period is latched only at a wrap, so a live cfg_rd_div change
         // never truncates or stretches the count in progress.
         if (state != ST_RUN || pps_edge || wrap) begin
            div_cnt <= '0;
            div_cur <= div_cfg;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end

         if (state != ST_RUN || pps_edge) burst_cnt <= '0;
         else if (pop)                    burst_cnt <= burst_cnt + BURST_W'(1);

         if (!active || pps_edge) wd_cnt <= '0;
         else                     wd_cnt <= wd_cnt + TMO_W'(1);
      end
   end

   // ---------------- strobes and sticky flags ----------------
   always_ff @(posedge clk240 or negedge rst_240_n) begin
      if (!rst_240_n) begin
         rng_rd    <= 1'b0;
         rd_en_o   <= 1'b0;
         decoy_sel <= 1'b0;
         pps_lost  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         rng_rd  <= pop;
         rd_en_o <= pop;
         if (pop) decoy_sel <= is_decoy;

         if (!en)         pps_lost <= 1'b0;
         else if (wd_exp) pps_lost <= 1'b1;

         if (!en)       underflow <= 1'b0;
         else if (miss) underflow <= 1'b1;
      end
   end

`ifdef DECOY_SCHED_STATS_EN
   logic [15:0] n_decoy, n_signal, n_miss;

   // Window counters are snapshotted to stat_* and restarted on every PPS edge.
   always_ff @(posedge clk240 or negedge rst_240_n) begin
      if (!rst_240_n) begin
         n_decoy     <= '0;
         n_signal    <= '0;
         n_miss      <= '0;
         stat_decoy  <= '0;
         stat_signal <= '0;
         stat_miss   <= '0;
      end else if (pps_edge) begin
         stat_decoy  <= n_decoy;
         stat_signal <= n_signal;
         stat_miss   <= n_miss;
         n_decoy     <= '0;
         n_signal    <= '0;
         n_miss      <= '0;
      end else begin
         if (pop && is_decoy)  n_decoy  <= sat_inc16(n_decoy);
         if (pop && !is_decoy) n_signal <= sat_inc16(n_signal);
         if (miss)             n_miss   <= sat_inc16(n_miss);
      end
   end
`else
   assign stat_decoy  = '0;
   assign stat_signal = '0;
   assign stat_miss   = '0;
`endif

endmodule

// File: tb/tb_decoy_sched.sv
// Bench for decoy_sched: directed multi-cycle sequences, a decision table and a random soak,
// all cross-checked every cycle against a timeline-based reference model.
// Ports of the DUT are all connected; PPS watchdog shortened to 1000 cycles.
module tb_decoy_sched;

   localparam int TMO = 1000;
   localparam int RC  = 4;

   logic        clk240 = 1'b0;
   logic        rst_240_n = 1'b0;
   logic        en = 1'b0, cfg_resync = 1'b0, pps_i = 1'b0, rng_empty = 1'b0;
   logic [7:0]  cfg_rd_div = 8'd6;
   logic [3:0]  cfg_thresh = 4'd2, rng_value = 4'd0;
   logic [15:0] cfg_burst_len = 16'd0;
   logic        rng_rd, rd_en_o, decoy_sel, decoy_rst, busy, pps_lost, underflow;
   logic [15:0] stat_decoy, stat_signal, stat_miss;

   always #5 clk240 = ~clk240;

   decoy_sched #(.PPS_TIMEOUT(TMO)) dut (
      .clk240(clk240), .rst_240_n(rst_240_n), .en(en), .cfg_rd_div(cfg_rd_div),
      .cfg_thresh(cfg_thresh), .cfg_burst_len(cfg_burst_len), .cfg_resync(cfg_resync),
      .pps_i(pps_i), .rng_empty(rng_empty), .rng_value(rng_value),
      .rng_rd(rng_rd), .rd_en_o(rd_en_o), .decoy_sel(decoy_sel), .decoy_rst(decoy_rst),
      .busy(busy), .pps_lost(pps_lost), .underflow(underflow),
      .stat_decoy(stat_decoy), .stat_signal(stat_signal), .stat_miss(stat_miss)
   );

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (absolute-cycle timeline) ----------------
   localparam int MD_IDLE = 0, MD_WAIT = 1, MD_RST = 2, MD_RUN = 3, MD_HOLD = 4, MD_ERR = 5;
   int cyc = 0, m_mode, rst_end, next_tick, wd_start, strobes;
   bit [2:0] psh;
   bit e_rd, e_sel, e_under, e_lost;
   int n_dec, n_sig, n_mis, s_dec, s_sig, s_mis;

   task automatic model_reset();
      m_mode = MD_IDLE; psh = '0; strobes = 0;
      e_rd = 0; e_sel = 0; e_under = 0; e_lost = 0;
      n_dec = 0; n_sig = 0; n_mis = 0; s_dec = 0; s_sig = 0; s_mis = 0;
   endtask

   task automatic model_step();
      bit edge_now, act, tick, pop, miss, tmo;
      int divc, nm;
      edge_now = psh[1] && !psh[2];
      psh = {psh[1:0], pps_i};
      divc = (cfg_rd_div < 2) ? 2 : int'(cfg_rd_div);
      act  = (m_mode == MD_RST) || (m_mode == MD_RUN) || (m_mode == MD_HOLD);
      tick = (m_mode == MD_RUN) && en && !edge_now && (cyc == next_tick);
      pop  = tick && !rng_empty;
      miss = tick && rng_empty;
      tmo  = act && !edge_now && (cyc - wd_start == TMO - 1);
      e_rd = pop;
      if (pop) e_sel = (rng_value < cfg_thresh);
      e_under = en ? (e_under || miss) : 1'b0;
      e_lost  = en ? (e_lost || tmo) : 1'b0;
      if (edge_now) begin
         s_dec = n_dec; s_sig = n_sig; s_mis = n_mis; n_dec = 0; n_sig = 0; n_mis = 0;
      end else begin
         if (pop && e_sel && n_dec < 65535) n_dec++;
         if (pop && !e_sel && n_sig < 65535) n_sig++;
         if (miss && n_mis < 65535) n_mis++;
      end
      nm = m_mode;
      if (!en) nm = MD_IDLE;
      else if (tmo) nm = MD_ERR;
      else case (m_mode)
         MD_IDLE: nm = MD_WAIT;
         MD_WAIT: if (edge_now) begin nm = MD_RST; rst_end = cyc + RC; wd_start = cyc + 1; end
         MD_RST: begin
            if (edge_now) wd_start = cyc + 1;
            if (cyc == rst_end) begin nm = MD_RUN; next_tick = cyc + divc; strobes = 0; end
         end
         MD_RUN, MD_HOLD: begin
            if (edge_now) begin
               strobes = 0; wd_start = cyc + 1;
               if (cfg_resync) begin nm = MD_RST; rst_end = cyc + RC; end
               else begin nm = MD_RUN; next_tick = cyc + divc; end
            end else if (m_mode == MD_RUN) begin
               if (cyc == next_tick) next_tick = cyc + divc;
               if (pop) begin
                  strobes++;
                  if (cfg_burst_len != 0 && strobes == int'(cfg_burst_len)) nm = MD_HOLD;
               end
            end
         end
         default: nm = m_mode;
      endcase
      m_mode = nm;
   endtask

   // ---------------- FWFT FIFO emulation for the fixed 1,2,3 pattern ----------------
   int pat[3] = '{1, 2, 3};
   int pat_idx = 0;
   bit pat_mode = 0, pend_pop = 0;

   task automatic cycle();
      bit e_rst, e_busy;
      model_step();
      e_rst  = !((m_mode == MD_RUN) || (m_mode == MD_HOLD));
      e_busy = (m_mode == MD_RST) || (m_mode == MD_RUN) || (m_mode == MD_HOLD);
      @(posedge clk240); #1;
      chk("model_outputs", {rng_rd, rd_en_o, decoy_sel, decoy_rst, busy, pps_lost, underflow},
          {e_rd, e_rd, e_sel, e_rst, e_busy, e_lost, e_under});
`ifdef DECOY_SCHED_STATS_EN
      chk("model_stats", {stat_decoy, stat_signal, stat_miss},
          {16'(s_dec), 16'(s_sig), 16'(s_mis)});
`endif
      cyc++;
      if (pend_pop) pat_idx++;
      pend_pop = rng_rd;
      if (pat_mode) rng_value = 4'(pat[pat_idx % 3]);
   endtask

   typedef struct { logic [3:0] val; logic [3:0] thr; logic exp_sel; } dec_vec_t;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      dec_vec_t tbl[10];
      int k, cnt, ns;
      int pos[3];
      logic sel[3];
      tbl[0] = '{4'd1,  4'd2,  1'b1};  tbl[1] = '{4'd2,  4'd2,  1'b0};
      tbl[2] = '{4'd3,  4'd2,  1'b0};  tbl[3] = '{4'd0,  4'd0,  1'b0};
      tbl[4] = '{4'd15, 4'd15, 1'b0};  tbl[5] = '{4'd14, 4'd15, 1'b1};
      tbl[6] = '{4'd0,  4'd1,  1'b1};  tbl[7] = '{4'd8,  4'd8,  1'b0};
      tbl[8] = '{4'd7,  4'd8,  1'b1};  tbl[9] = '{4'd15, 4'd0,  1'b0};

      // ---- reset values ----
      model_reset();
      #12;
      chk("reset_outputs", {rng_rd, rd_en_o, decoy_sel, decoy_rst, busy, pps_lost, underflow},
          7'b0001000);
      chk("reset_stats", {stat_decoy, stat_signal, stat_miss}, 48'd0);
      @(posedge clk240); #4; rst_240_n = 1'b1;

      // ---- 1: arm on PPS, 6-cycle strobes, pattern 1,2,3 vs thresh 2 ----
      en = 1; cfg_rd_div = 6; cfg_thresh = 2; pat_mode = 1; pat_idx = 0; rng_value = 4'd1;
      repeat (3) cycle();
      pps_i = 1; k = 0;
      do begin cycle(); k++; end while (decoy_rst && k < 20);
      chk("rst_release_delay", k, 7);
      k = 0; ns = 0;
      for (int j = 0; j < 40 && ns < 3; j++) begin
         cycle(); k++;
         if (rng_rd) begin pos[ns] = k; sel[ns] = decoy_sel; ns++; end
      end
      chk("strobe_count", ns, 3);
      chk("first_strobe", pos[0], 6);
      chk("strobe_gap1", pos[1] - pos[0], 6);
      chk("strobe_gap2", pos[2] - pos[1], 6);
      chk("sel_seq", {sel[0], sel[1], sel[2]}, 3'b100);

      // ---- decision table ----
      pat_mode = 0;
      for (int i = 0; i < 10; i++) begin
         rng_value = tbl[i].val; cfg_thresh = tbl[i].thr; k = 0;
         do begin cycle(); k++; end while (!rng_rd && k < 20);
         chk("tbl_strobe_seen", rng_rd, 1'b1);
         chk("tbl_decoy_sel", decoy_sel, tbl[i].exp_sel);
      end

      // ---- 2: burst of 5 per PPS window, then HOLD ----
      cfg_burst_len = 5;
      for (int w = 0; w < 2; w++) begin
         pps_i = 0; repeat (4) cycle();
         pps_i = 1; repeat (3) cycle();
         cnt = 0;
         repeat (77) begin cycle(); cnt += int'(rng_rd); end
         chk("burst_pulses", cnt, 5);
         chk("hold_busy_rst", {busy, decoy_rst}, 2'b10);
      end

      // ---- 3: two ticks with RNG empty ----
      cfg_burst_len = 0; cfg_thresh = 2; rng_value = 0;
      pps_i = 0; repeat (4) cycle();
      pps_i = 1; repeat (3) cycle();
      k = 0;
      do begin cycle(); k++; end while (!rng_rd && k < 20);
      chk("pre_empty_sel", {rng_rd, decoy_sel}, 2'b11);
      chk("underflow_pre", underflow, 1'b0);
      rng_empty = 1; rng_value = 15; cnt = 0;
      repeat (12) begin cycle(); cnt += int'(rng_rd); end
      rng_empty = 0;
      chk("empty_no_pop", cnt, 0);
      chk("underflow_set", underflow, 1'b1);
      chk("sel_held", decoy_sel, 1'b1);
      pps_i = 0; repeat (4) cycle();
      pps_i = 1; repeat (4) cycle();
`ifdef DECOY_SCHED_STATS_EN
      chk("stat_miss_window", stat_miss, 16'd2);
`else
      chk("stat_tied_off", {stat_decoy, stat_signal, stat_miss}, 48'd0);
`endif

      // ---- 4: PPS edge on a tick (no resync); 5: watchdog to ERR ----
      k = 0;
      do begin cycle(); k++; end while (!rng_rd && k < 20);
      k = 0; pps_i = 0;
      do begin if (k == 3) pps_i = 1; cycle(); k++; end while (!rng_rd && k < 40);
      chk("pps_tick_collide", k, 12);
      do begin cycle(); k++; end while (!pps_lost && k < 1200);
      chk("timeout_delay", k, 1006);
      chk("err_outputs", {decoy_rst, busy, pps_lost}, 3'b101);
      cnt = 0;
      repeat (20) begin cycle(); cnt += int'(rng_rd); end
      chk("err_no_strobe", cnt, 0);
      en = 0; cycle();
      chk("en_off_clear", {pps_lost, underflow, busy, decoy_rst}, 4'b0001);

      // ---- 6: async reset mid-RUN ----
      en = 1; pps_i = 0; repeat (4) cycle();
      pps_i = 1; k = 0;
      do begin cycle(); k++; end while (!rng_rd && k < 40);
      chk("pre_reset_strobe", rng_rd, 1'b1);
      #2 rst_240_n = 1'b0;
      #1;
      chk("async_reset_outputs",
          {rng_rd, rd_en_o, decoy_sel, decoy_rst, busy, pps_lost, underflow}, 7'b0001000);
      model_reset(); pps_i = 0;
      repeat (2) @(posedge clk240);
      #4 rst_240_n = 1'b1;
      repeat (20) cycle();
      chk("post_reset_idle", busy, 1'b0);
      pps_i = 1; repeat (10) cycle();
      chk("post_reset_rearm", busy, 1'b1);

      // ---- random soak ----
      begin
         int gap = 0, en_off = 0;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) cfg_rd_div = 8'($urandom_range(0, 9));
            if ($urandom_range(0, 49) == 0) cfg_thresh = 4'($urandom);
            if (i % 300 == 0) begin
               cfg_burst_len = 16'($urandom_range(0, 12));
               cfg_resync = 1'($urandom_range(0, 1));
            end
            rng_empty = ($urandom_range(0, 7) == 0);
            rng_value = 4'($urandom);
            if (gap == 0) gap = $urandom_range(60, 400);
            gap--;
            pps_i = (gap < 4);
            if (en_off == 0 && $urandom_range(0, 599) == 0) en_off = 3;
            if (en_off > 0) begin en = 0; en_off--; end else en = 1;
            cycle();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
